// File: rtl/reset_sequencer.sv
// Central reset generator: holds every domain in reset, releases them in order, re-issues on sw/wdt.
// Optional RESET_SEQ_SYNC_IN_EN adds 2-flop synchronisers on sw_req, kick and wdt_en.
module reset_sequencer #(
  parameter int N_STAGES     = 3,
  parameter int HOLD_CYCLES  = 511,
  parameter int STAGE_GAP    = 16,
  parameter int WDT_CYCLES   = 65535,
  parameter int PULSE_CYCLES = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sw_req,
  input  logic                kick,
  input  logic                wdt_en,
  output logic [N_STAGES-1:0] rst_stage,
  output logic                ready,
  output logic [1:0]          cause
);

  localparam int HG_MAX  = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CNT_MAX = (HG_MAX > PULSE_CYCLES) ? HG_MAX : PULSE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int WDT_W   = $clog2(WDT_CYCLES) + 1;
  localparam int STG_W   = $clog2(N_STAGES + 1) + 1;

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2,
    S_PULSE   = 2'd3
  } state_t;

  logic sw_in, kick_in, wdt_en_in;

`ifdef RESET_SEQ_SYNC_IN_EN
  logic [2:0] sync1_q, sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {sw_req, kick, wdt_en};
      sync2_q <= sync1_q;
    end
  end

  assign {sw_in, kick_in, wdt_en_in} = sync2_q;
`else
  assign {sw_in, kick_in, wdt_en_in} = {sw_req, kick, wdt_en};
`endif

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STG_W-1:0]    stg_q, stg_d;
  logic [WDT_W-1:0]    wdt_cnt_q, wdt_cnt_d;
  logic [N_STAGES-1:0] rst_stage_q, rst_stage_d;
  logic                ready_q, ready_d;
  logic [1:0]          cause_q, cause_d;
  logic                sw_prev_q, sw_prev_d;
  logic                sw_rise, wdt_exp, enter_pulse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_HOLD;
      cnt_q       <= '0;
      stg_q       <= '0;
      wdt_cnt_q   <= '0;
      rst_stage_q <= '1;
      ready_q     <= 1'b0;
      cause_q     <= 2'b00;
      sw_prev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stg_q       <= stg_d;
      wdt_cnt_q   <= wdt_cnt_d;
      rst_stage_q <= rst_stage_d;
      ready_q     <= ready_d;
      cause_q     <= cause_d;
      sw_prev_q   <= sw_prev_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stg_d       = stg_q;
    wdt_cnt_d   = '0;
    rst_stage_d = rst_stage_q;
    ready_d     = ready_q;
    cause_d     = cause_q;
    sw_prev_d   = sw_in;
    enter_pulse = 1'b0;
    sw_rise     = sw_in & ~sw_prev_q;
    wdt_exp     = wdt_en_in & ~kick_in & (wdt_cnt_q == WDT_W'(WDT_CYCLES - 1));

    case (state_q)
      S_HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          cnt_d          = '0;
          rst_stage_d[0] = 1'b0;
          stg_d          = STG_W'(1);
          state_d        = S_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RELEASE: begin
        // stg_q is the index of the next stage to release; N_STAGES means all are out
        if (stg_q == STG_W'(N_STAGES)) begin
          ready_d = 1'b1;
          cnt_d   = '0;
          state_d = S_RUN;
        end else if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
          cnt_d = '0;
          for (int i = 0; i < N_STAGES; i++) begin
            if (STG_W'(i) == stg_q) rst_stage_d[i] = 1'b0;
          end
          stg_d = stg_q + STG_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        // sw has priority over the watchdog; a kick on the expiry edge masks it in wdt_exp
        if (sw_rise) begin
          cause_d     = 2'b01;
          enter_pulse = 1'b1;
        end else if (wdt_exp) begin
          cause_d     = 2'b10;
          enter_pulse = 1'b1;
        end else if (wdt_en_in && !kick_in) begin
          wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
        end
      end
      S_PULSE: begin
        if (cnt_q == CNT_W'(PULSE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_HOLD;
    endcase

    if (enter_pulse) begin
      state_d     = S_PULSE;
      rst_stage_d = '1;
      ready_d     = 1'b0;
      cnt_d       = '0;
      stg_d       = '0;
      wdt_cnt_d   = '0;
    end
  end

  assign rst_stage = rst_stage_q;
  assign ready     = ready_q;
  assign cause     = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: timed expectation table plus hand-written corner sequences.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst, sw_req, kick, wdt_en;
  logic [2:0] rst_stage;
  logic       ready;
  logic [1:0] cause;

  reset_sequencer #(
    .N_STAGES(3), .HOLD_CYCLES(8), .STAGE_GAP(4), .WDT_CYCLES(20), .PULSE_CYCLES(5)
  ) dut (
    .clk(clk), .rst(rst), .sw_req(sw_req), .kick(kick), .wdt_en(wdt_en),
    .rst_stage(rst_stage), .ready(ready), .cause(cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic [2:0] stage;
    logic       rdy;
    logic [1:0] cause;
  } vec_t;

  typedef struct {
    int         at;
    logic [2:0] stage;
    logic       rdy;
    logic [1:0] cause;
    string      name;
  } exp_t;

  vec_t tbl[15];
  exp_t sb[$];
  int   cyc, base, errors, checks;

  task automatic compare(input string nm, input logic [2:0] s, input logic r, input logic [1:0] c);
    checks++;
    if (rst_stage !== s || ready !== r || cause !== c) begin
      errors++;
      $display("FAIL %s @cyc %0d: got stage=%b ready=%b cause=%b, want stage=%b ready=%b cause=%b",
               nm, cyc, rst_stage, ready, cause, s, r, c);
    end
  endtask

  task automatic push(input int d, input logic [2:0] s, input logic r, input logic [1:0] c,
                      input string nm);
    exp_t e;
    int   pos;
    e.at = cyc + d; e.stage = s; e.rdy = r; e.cause = c; e.name = nm;
    pos = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].at > e.at) begin
        pos = i;
        break;
      end
    end
    sb.insert(pos, e);
  endtask

  // One clock: sample just after the falling edge, retire due expectations, then settle.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      if (e.at < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cyc %0d skipped at cyc %0d", e.name, e.at, cyc);
      end else begin
        compare(e.name, e.stage, e.rdy, e.cause);
      end
    end
    #1;
  endtask

  task automatic apply_table(input int max_n);
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].n <= max_n)
        push(tbl[i].n, tbl[i].stage, tbl[i].rdy, tbl[i].cause, $sformatf("seq_n%0d", tbl[i].n));
    end
  endtask

  initial begin
    // edge number after rst release -> outputs, with wdt_en=1 and no kick
    tbl[0]  = '{1,  3'b111, 1'b0, 2'b00};
    tbl[1]  = '{7,  3'b111, 1'b0, 2'b00};
    tbl[2]  = '{8,  3'b110, 1'b0, 2'b00};
    tbl[3]  = '{11, 3'b110, 1'b0, 2'b00};
    tbl[4]  = '{12, 3'b100, 1'b0, 2'b00};
    tbl[5]  = '{15, 3'b100, 1'b0, 2'b00};
    tbl[6]  = '{16, 3'b000, 1'b0, 2'b00};
    tbl[7]  = '{17, 3'b000, 1'b1, 2'b00};
    tbl[8]  = '{36, 3'b000, 1'b1, 2'b00};
    tbl[9]  = '{37, 3'b111, 1'b0, 2'b10};
    tbl[10] = '{41, 3'b111, 1'b0, 2'b10};
    tbl[11] = '{49, 3'b111, 1'b0, 2'b10};
    tbl[12] = '{50, 3'b110, 1'b0, 2'b10};
    tbl[13] = '{58, 3'b000, 1'b0, 2'b10};
    tbl[14] = '{59, 3'b000, 1'b1, 2'b10};

    errors = 0; checks = 0; cyc = 0;
    rst = 1'b1; sw_req = 1'b0; kick = 1'b0; wdt_en = 1'b1;
    repeat (3) tick();
    compare("reset_state", 3'b111, 1'b0, 2'b00);

    // power-on release, watchdog expiry and its re-release
    rst = 1'b0;
    base = cyc;
    apply_table(99);
    repeat (59) tick();

    // regular kicks keep RUN alive
    for (int i = 0; i < 200; i++) begin
      kick = (i % 10 == 0);
      if (i % 25 == 24) push(1, 3'b000, 1'b1, 2'b10, "kick_run");
      tick();
    end
    kick = 1'b0;
    wdt_en = 1'b0;
    tick();

    // sw_req rising edge, then held high through the re-release
    sw_req = 1'b1;
    push(1,  3'b111, 1'b0, 2'b01, "sw_pulse");
    push(13, 3'b111, 1'b0, 2'b01, "sw_hold");
    push(14, 3'b110, 1'b0, 2'b01, "sw_stage0");
    push(23, 3'b000, 1'b1, 2'b01, "sw_run");
    push(40, 3'b000, 1'b1, 2'b01, "sw_held_no_rerun");
    repeat (40) tick();
    sw_req = 1'b0;
    tick();

    // sw rising edge on the same edge as watchdog expiry
    wdt_en = 1'b1;
    push(19, 3'b000, 1'b1, 2'b01, "pre_expiry");
    push(20, 3'b111, 1'b0, 2'b01, "sw_wdt_same_edge");
    repeat (19) tick();
    sw_req = 1'b1;
    tick();
    wdt_en = 1'b0;
    push(22, 3'b000, 1'b1, 2'b01, "sw_wdt_rerun");
    repeat (22) tick();
    sw_req = 1'b0;
    tick();

    // kick on the expiry edge suppresses the reset
    wdt_en = 1'b1;
    push(20, 3'b000, 1'b1, 2'b01, "kick_at_expiry");
    push(25, 3'b000, 1'b1, 2'b01, "kick_after");
    repeat (19) tick();
    kick = 1'b1;
    tick();
    kick = 1'b0;
    repeat (5) tick();
    wdt_en = 1'b0;
    tick();

    // watchdog reset, then sw pulses in PULSE and HOLD must be ignored
    wdt_en = 1'b1;
    push(20, 3'b111, 1'b0, 2'b10, "wdt_second");
    repeat (20) tick();
    wdt_en = 1'b0;
    push(12, 3'b111, 1'b0, 2'b10, "ign_hold");
    push(13, 3'b110, 1'b0, 2'b10, "ign_stage0");
    push(15, 3'b110, 1'b0, 2'b10, "ign_release");
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    repeat (5) tick();
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    repeat (8) tick();

    // async reset in RELEASE, no clock edge in between
    #2;
    rst = 1'b1;
    #1;
    compare("rst_async", 3'b111, 1'b0, 2'b00);
    repeat (2) tick();
    wdt_en = 1'b1;
    rst = 1'b0;
    apply_table(17);
    repeat (17) tick();

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: %0d expectations never retired, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
